multicycle_main_decoder: RTL and testbench
==========================================

// Module: multicycle_main_decoder
// PURPOSE
//  Main control FSM for the multicycle ARMv4 datapath. Replaces the single-cycle main decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK from Op/Funct and drives datapath mux selects and write strobes.
//  Adds a req/ready memory handshake, a wait-state watchdog and fault reporting.
//  Sits between the instruction register and the datapath. Condition-check logic gates RegW/MemW/NextPC downstream.
// PARAMETERS
//  TIMEOUT    16  max cycles mem_req may stay unanswered before FAULT (>=1)
//  TIMEOUT_W  5   watchdog counter width; must hold TIMEOUT
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous, active-high reset
//  Op         in   2  instr[27:26]: 00 data-proc, 01 mem, 10 branch, 11 undefined
//  Funct      in   6  instr[25:20]: [5]=I, [0]=L/S, [4]=link bit for branch
//  mem_ready  in   1  memory completes the current access this cycle
//  mem_req    out  1  memory access request
//  IRWrite    out  1  load instruction register
//  AdrSrc     out  1  0=PC, 1=ALU result as memory address
//  ALUSrcA    out  2  00=Rn, 01=PC, 10=PC+4
//  ALUSrcB    out  2  00=Rm, 01=Ext imm, 10=const 4
//  ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALU direct
//  ImmSrc     out  2  = Op (combinational from Op)
//  RegSrc     out  2  [0]=(Op==10), [1]=(Op==01)
//  NextPC     out  1  PC write strobe
//  RegW       out  1  register-file write strobe
//  MemW       out  1  memory write strobe
//  Branch     out  1  branch strobe
//  ALUOp      out  1  ALU decoder uses Funct[4:1]
//  LinkW      out  1  write PC+4 to R14 (only with MCD_BL_EN)
//  fault      out  1  sticky fault flag
//  fault_code out  2  00 none, 01 mem timeout, 10 undefined Op
// BEHAVIOUR
//  Reset: state=FETCH, watchdog=0, fault=0, fault_code=00. All strobes (mem_req, IRWrite, NextPC, RegW, MemW, Branch, LinkW) are 0 while rst=1.
//  Mux selects take their FETCH values during reset. rst is asynchronous and aborts any state, including mid-access.
//  Outputs are Moore, decoded from the state register. Only ImmSrc/RegSrc decode directly from Op.
//  FETCH:     mem_req=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
//             IRWrite=NextPC=1 only in the cycle mem_ready=1; then go to DECODE.
//  DECODE:    ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
//             Op 00: Funct[5]=1 -> EXECI, else EXECR. Op 01 -> MEMADR. Op 10 -> BRANCH. Op 11 -> FAULT(10).
//  EXECR:     ALUSrcA=00, ALUSrcB=00, ALUOp=1 -> ALUWB.
//  EXECI:     ALUSrcA=00, ALUSrcB=01, ALUOp=1 -> ALUWB.
//  ALUWB:     ResultSrc=00, RegW=1 -> FETCH.
//  MEMADR:    ALUSrcA=00, ALUSrcB=01 -> Funct[0]=1 ? MEMRD : MEMWR.
//  MEMRD:     mem_req=1, AdrSrc=1. On mem_ready -> MEMWB.
//  MEMWB:     ResultSrc=01, RegW=1 -> FETCH.
//  MEMWR:     mem_req=1, AdrSrc=1. MemW=1 only in the mem_ready cycle, then -> FETCH.
//  BRANCH:    ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
//  FAULT:     absorbing until rst. All strobes 0; fault=1.
//  Latency (mem_ready held 1): B 3 cycles, data-proc 4, STR 4, LDR 5.
//  Each wait cycle in FETCH/MEMRD/MEMWR adds 1 cycle.
//  Watchdog: cleared on entry to any mem_req state and on mem_ready; increments each cycle mem_req=1 and mem_ready=0.
//    When count reaches TIMEOUT-1 with mem_ready=0 -> FAULT(01) next cycle.
//    mem_ready in that same cycle wins: the access completes, no fault.
//  mem_ready outside a mem_req state is ignored.
//  Illegal or unencoded state register value -> FETCH next cycle.
// CONFIGURATION
//  MCD_BL_EN defined:
//    BRANCH with Funct[4]=1 goes to LINK instead of FETCH.
//    LINK: ALUSrcA=10, ALUSrcB=10, ResultSrc=10, RegW=1, LinkW=1 -> FETCH. BL takes 4 cycles.
//  MCD_BL_EN undefined: Funct[4] ignored. LinkW is tied 0 and LINK does not exist. BL behaves as B.
// TESTING
//  Reset then Op=00, Funct=6'b000100, ready=1 -> states FETCH,DECODE,EXECR,ALUWB. RegW=1 in cycle 4. IRWrite=1 in cycle 1 only.
//  Op=01, Funct[0]=1, ready low 3 cycles in MEMRD -> mem_req high 4 cycles, MEMWB reached. LDR total 8 cycles. fault=0.
//  Op=01, Funct[0]=0, ready=1 -> MemW=1 for exactly 1 cycle (cycle 4) with AdrSrc=1.
//  TIMEOUT=4, ready held 0 in FETCH -> fault=1, fault_code=01 after 4 cycles. A later ready has no effect.
//  Op=11 -> fault_code=10 in cycle 3. Assert rst mid-MEMWR -> strobes drop 0 at once; FETCH after release.
//  MCD_BL_EN, Op=10, Funct[4]=1 -> Branch in cycle 3, LinkW+RegW in cycle 4. Without the macro: 3 cycles, LinkW=0.

Source files
------------

// File: rtl/multicycle_main_decoder.sv
// Multicycle ARMv4 main control FSM with memory req/ready handshake, wait-state watchdog and fault reporting.
// Optional branch-with-link support is enabled by defining MCD_BL_EN.
module multicycle_main_decoder #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned TIMEOUT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       LinkW,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXECR  = 4'd2,
        EXECI  = 4'd3,
        ALUWB  = 4'd4,
        MEMADR = 4'd5,
        MEMRD  = 4'd6,
        MEMWB  = 4'd7,
        MEMWR  = 4'd8,
        BRANCH = 4'd9,
`ifdef MCD_BL_EN
        LINK   = 4'd11,
`endif
        FAULT  = 4'd10
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic                 r_fault;
    logic [1:0]           r_fault_code;
    logic                 w_mem_state;
    logic                 w_timeout;
    logic                 w_undef;
    logic                 w_unused;

    assign w_unused    = ^{Funct[4:1]};
    assign w_mem_state = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    assign w_timeout   = w_mem_state && !mem_ready && (r_wdog == TIMEOUT_W'(TIMEOUT - 1));
    assign w_undef     = (r_state == DECODE) && (Op == 2'b11);

    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Watchdog only advances while an access is pending; entering any mem state starts it from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog       <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else begin
            if (w_mem_state && !mem_ready && !w_timeout) begin
                r_wdog <= r_wdog + TIMEOUT_W'(1);
            end else begin
                r_wdog <= '0;
            end
            if (w_timeout) begin
                r_fault      <= 1'b1;
                r_fault_code <= 2'b01;
            end else if (w_undef) begin
                r_fault      <= 1'b1;
                r_fault_code <= 2'b10;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        IRWrite      = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        NextPC       = 1'b0;
        RegW         = 1'b0;
        MemW         = 1'b0;
        Branch       = 1'b0;
        ALUOp        = 1'b0;
        LinkW        = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
                if (w_timeout)      w_state_next = FAULT;
                else if (mem_ready) w_state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   w_state_next = Funct[5] ? EXECI : EXECR;
                    2'b01:   w_state_next = MEMADR;
                    2'b10:   w_state_next = BRANCH;
                    default: w_state_next = FAULT;
                endcase
            end
            EXECR: begin
                ALUOp        = 1'b1;
                w_state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcB      = 2'b01;
                ALUOp        = 1'b1;
                w_state_next = ALUWB;
            end
            ALUWB: begin
                RegW         = 1'b1;
                w_state_next = FETCH;
            end
            MEMADR: begin
                ALUSrcB      = 2'b01;
                w_state_next = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (w_timeout)      w_state_next = FAULT;
                else if (mem_ready) w_state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc    = 2'b01;
                RegW         = 1'b1;
                w_state_next = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                MemW    = mem_ready;
                if (w_timeout)      w_state_next = FAULT;
                else if (mem_ready) w_state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
`ifdef MCD_BL_EN
                w_state_next = Funct[4] ? LINK : FETCH;
`else
                w_state_next = FETCH;
`endif
            end
`ifdef MCD_BL_EN
            LINK: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                RegW         = 1'b1;
                LinkW        = 1'b1;
                w_state_next = FETCH;
            end
`endif
            FAULT: begin
                w_state_next = FAULT;
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
        // Reset leaves the FETCH mux selects visible but must silence every strobe.
        if (rst) begin
            mem_req = 1'b0;
            IRWrite = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            Branch  = 1'b0;
            LinkW   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_main_decoder.sv
// Self-checking bench for multicycle_main_decoder: instruction table plus handshake, watchdog and reset corner cases.
// Honours MCD_BL_EN the same way as the design.
module tb_multicycle_main_decoder;

    typedef struct packed {
        logic       mreq, irw, npc, regw, memw, br, adr, aluop, linkw, flt;
        logic [1:0] fc, sa, sb, rs;
    } sig_t;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [5:0] funct;
        int         len;
        sig_t       seq [6];
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b000000;
    logic       mem_ready = 1'b1;
    logic       mem_req, IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, LinkW, fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, fault_code;

    int checks = 0;
    int errors = 0;

    sig_t exp_q [$];
    logic rdy_q [$];
    vec_t vec [6];

    sig_t S_RST, S_FETCH, S_FETCH_W, S_DECODE, S_EXECR, S_EXECI, S_ALUWB, S_MEMADR;
    sig_t S_MEMRD, S_MEMWB, S_MEMWR, S_MEMWR_W, S_BRANCH, S_LINK, S_FAULT01, S_FAULT10;

    multicycle_main_decoder #(.TIMEOUT(4), .TIMEOUT_W(3)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp),
        .LinkW(LinkW), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    function automatic sig_t mk(input logic [9:0] strobes, input logic [1:0] fc,
                                input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs);
        sig_t s;
        {s.mreq, s.irw, s.npc, s.regw, s.memw, s.br, s.adr, s.aluop, s.linkw, s.flt} = strobes;
        s.fc = fc;
        s.sa = sa;
        s.sb = sb;
        s.rs = rs;
        return s;
    endfunction

    function automatic sig_t sample();
        sig_t s;
        {s.mreq, s.irw, s.npc, s.regw, s.memw, s.br, s.adr, s.aluop, s.linkw, s.flt} =
            {mem_req, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, LinkW, fault};
        s.fc = fault_code;
        s.sa = ALUSrcA;
        s.sb = ALUSrcB;
        s.rs = ResultSrc;
        return s;
    endfunction

    task automatic check_sig(input string name, input int cyc, input sig_t exp);
        sig_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b required %b (mreq,irw,npc,regw,memw,br,adr,aluop,linkw,flt,fc,sa,sb,rs)",
                     name, cyc, got, exp);
        end
        checks++;
        if (ImmSrc !== Op || RegSrc !== {Op == 2'b01, Op == 2'b10}) begin
            errors++;
            $display("FAIL %s cycle %0d imm/regsrc: got %b/%b required %b/%b",
                     name, cyc, ImmSrc, RegSrc, Op, {Op == 2'b01, Op == 2'b10});
        end
    endtask

    // Runs n cycles, popping one ready value and one expected output set per cycle.
    task automatic run_cycles(input string name, input logic [1:0] op, input logic [5:0] funct, input int n);
        sig_t exp;
        Op    = op;
        Funct = funct;
        for (int c = 1; c <= n; c++) begin
            mem_ready = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s cycle %0d: scoreboard empty, required an entry", name, c);
            end else begin
                exp = exp_q.pop_front();
                check_sig(name, c, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        check_sig(name, 0, S_RST);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_vec(input int i, input string name, input logic [1:0] op, input logic [5:0] funct,
                           input int len, input sig_t s0, input sig_t s1, input sig_t s2,
                           input sig_t s3, input sig_t s4);
        vec[i].name   = name;
        vec[i].op     = op;
        vec[i].funct  = funct;
        vec[i].len    = len;
        vec[i].seq[0] = s0;
        vec[i].seq[1] = s1;
        vec[i].seq[2] = s2;
        vec[i].seq[3] = s3;
        vec[i].seq[4] = s4;
        vec[i].seq[5] = S_FETCH;
    endtask

    task automatic run_vec(input int i);
        for (int c = 0; c < vec[i].len; c++) begin
            exp_q.push_back(vec[i].seq[c]);
            rdy_q.push_back(1'b1);
        end
        run_cycles(vec[i].name, vec[i].op, vec[i].funct, vec[i].len);
    endtask

    task automatic push(input sig_t s, input logic rdy);
        exp_q.push_back(s);
        rdy_q.push_back(rdy);
    endtask

    initial begin
        //                 strobes mreq,irw,npc,regw,memw,br,adr,aluop,linkw,flt
        S_RST     = mk(10'b0000000000, 2'b00, 2'b01, 2'b10, 2'b10);
        S_FETCH   = mk(10'b1110000000, 2'b00, 2'b01, 2'b10, 2'b10);
        S_FETCH_W = mk(10'b1000000000, 2'b00, 2'b01, 2'b10, 2'b10);
        S_DECODE  = mk(10'b0000000000, 2'b00, 2'b01, 2'b10, 2'b10);
        S_EXECR   = mk(10'b0000000100, 2'b00, 2'b00, 2'b00, 2'b00);
        S_EXECI   = mk(10'b0000000100, 2'b00, 2'b00, 2'b01, 2'b00);
        S_ALUWB   = mk(10'b0001000000, 2'b00, 2'b00, 2'b00, 2'b00);
        S_MEMADR  = mk(10'b0000000000, 2'b00, 2'b00, 2'b01, 2'b00);
        S_MEMRD   = mk(10'b1000001000, 2'b00, 2'b00, 2'b00, 2'b00);
        S_MEMWB   = mk(10'b0001000000, 2'b00, 2'b00, 2'b00, 2'b01);
        S_MEMWR   = mk(10'b1000101000, 2'b00, 2'b00, 2'b00, 2'b00);
        S_MEMWR_W = mk(10'b1000001000, 2'b00, 2'b00, 2'b00, 2'b00);
        S_BRANCH  = mk(10'b0000010000, 2'b00, 2'b10, 2'b01, 2'b10);
        S_LINK    = mk(10'b0001000010, 2'b00, 2'b10, 2'b10, 2'b10);
        S_FAULT01 = mk(10'b0000000001, 2'b01, 2'b00, 2'b00, 2'b00);
        S_FAULT10 = mk(10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00);

        set_vec(0, "dp_reg", 2'b00, 6'b000100, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH);
        set_vec(1, "dp_imm", 2'b00, 6'b100000, 4, S_FETCH, S_DECODE, S_EXECI, S_ALUWB, S_FETCH);
        set_vec(2, "ldr", 2'b01, 6'b000001, 5, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB);
        set_vec(3, "str", 2'b01, 6'b000000, 4, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH);
        set_vec(4, "b", 2'b10, 6'b000000, 3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH);
`ifdef MCD_BL_EN
        set_vec(5, "bl", 2'b10, 6'b010000, 4, S_FETCH, S_DECODE, S_BRANCH, S_LINK, S_FETCH);
`else
        set_vec(5, "bl", 2'b10, 6'b010000, 3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH);
`endif

        @(posedge clk);
        #1;
        do_reset("reset");

        for (int i = 0; i < 6; i++) run_vec(i);

        // LDR with three wait states in MEMRD: 8 cycles, no fault
        push(S_FETCH, 1'b1);
        push(S_DECODE, 1'b1);
        push(S_MEMADR, 1'b1);
        for (int k = 0; k < 3; k++) push(S_MEMRD, 1'b0);
        push(S_MEMRD, 1'b1);
        push(S_MEMWB, 1'b1);
        run_cycles("ldr_wait", 2'b01, 6'b000001, 8);

        // Unanswered fetch trips the watchdog; a late ready is ignored in FAULT
        for (int k = 0; k < 4; k++) push(S_FETCH_W, 1'b0);
        push(S_FAULT01, 1'b0);
        push(S_FAULT01, 1'b1);
        push(S_FAULT01, 1'b1);
        run_cycles("timeout", 2'b00, 6'b000000, 7);
        do_reset("reset_after_timeout");

        // Undefined Op faults out of DECODE
        push(S_FETCH, 1'b1);
        push(S_DECODE, 1'b1);
        push(S_FAULT10, 1'b1);
        push(S_FAULT10, 1'b1);
        run_cycles("undef_op", 2'b11, 6'b000000, 4);
        do_reset("reset_after_undef");

        // Reset asserted while a store is waiting, then a normal instruction
        push(S_FETCH, 1'b1);
        push(S_DECODE, 1'b1);
        push(S_MEMADR, 1'b1);
        push(S_MEMWR_W, 1'b0);
        run_cycles("str_wait", 2'b01, 6'b000000, 4);
        mem_ready = 1'b0;
        do_reset("reset_mid_memwr");
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
